// File: rtl/seq_count_pkg.sv
// Shared types for the loadable down-count timer.
// Holds the FSM state encoding used by the top level.
package seq_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_count_nb_bin_down_ld.sv
// Parameterized binary down-counter register.
// Load takes priority over decrement.
module seq_count_nb_bin_down_ld #(
  parameter int unsigned NBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [NBITS-1:0] ld_val,
  input  logic             dec,
  output logic [NBITS-1:0] q
);

  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  logic [NBITS-1:0] cnt_d;
  logic [NBITS-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (dec) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_count_3b_bin_down_timer.sv
// One-shot countdown timer: load a start value, count down
// on en, then hold a completion token until it is taken.
module seq_count_3b_bin_down_timer
  import seq_count_pkg::*;
#(
  parameter int unsigned nbits = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [nbits-1:0] req_data,
  output logic [nbits-1:0] out,
  output logic             done_val,
  input  logic             done_rdy
);

  localparam logic [nbits-1:0] ONE = nbits'(1);

  state_e           state_d;
  state_e           state_q;
  logic             req_rdy_q;
  logic             done_val_q;
  logic             ld;
  logic             dec;
  logic [nbits-1:0] cnt;

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_val) begin
          ld      = 1'b1;
          state_d = (req_data == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        if (en) begin
          dec = 1'b1;
          if (cnt == ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (done_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they
  // always agree with state_q without any output decode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_rdy_q  <= 1'b1;
      done_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_rdy_q  <= (state_d == IDLE);
      done_val_q <= (state_d == DONE);
    end
  end

  seq_count_nb_bin_down_ld #(
    .NBITS (nbits)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld),
    .ld_val (req_data),
    .dec    (dec),
    .q      (cnt)
  );

  assign req_rdy  = req_rdy_q;
  assign done_val = done_val_q;
  assign out      = cnt;

endmodule

// File: doc/seq_count_3b_bin_down_timer.md
Name: seq_count_3b_bin_down_timer

Overview:
- Loadable binary down-counter wrapped in a one-shot countdown timer with valid/ready handshakes at both ends.
- A producer loads a start value through a request port. The block decrements once per enabled cycle until it reaches zero, then presents a completion token to a consumer.
- It is the down-counting counterpart of the team's up/en counters. It serves as a delay and timeout primitive for control FSMs.

Parameters:
- nbits, 3, counter width in bits (must be >= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset: state resets on a rising clk edge when reset==0.
- en  input  1  count enable; decrement permitted only in COUNT.
- req_val  input  1  start value valid.
- req_rdy  output  1  block can accept a start value.
- req_data  input  nbits  start value.
- out  output  nbits  current counter value (registered).
- done_val  output  1  countdown complete, token pending.
- done_rdy  input  1  consumer accepts completion token.

Behaviour:
- Reset: reset==0 at a rising edge puts state in IDLE and clears the counter to 0. After reset: out=0, req_rdy=1, done_val=0. Reset mid-COUNT or mid-DONE aborts silently, with no done token.
- States are IDLE, COUNT and DONE. All outputs are Moore, derived from the registered state and counter only.
  - req_rdy = (state==IDLE).
  - done_val = (state==DONE).
  - out = counter.
- IDLE:
  - When req_val is 1, latch counter <= req_data in the same edge.
  - Next state is DONE if req_data==0, else COUNT.
  - en is ignored in IDLE; the counter holds its value otherwise.
- COUNT:
  - req_rdy=0, so req_val is ignored and no reload occurs.
  - When en is 1, counter <= counter-1. If counter==1 before the edge, next state is DONE.
  - When en is 0, the counter and state hold.
- DONE:
  - counter holds at 0 and done_val=1.
  - When done_rdy is 1, next state is IDLE. Otherwise hold indefinitely; en and req_val are ignored.
- Latency: a load of N>0 followed by continuous en gives done_val asserting exactly N cycles after the load edge. A load of 0 gives done_val on the cycle after the load.
- Back-to-back: at most one token per load. The DONE->IDLE transition costs one cycle, so the next load edge is no earlier than one cycle after the done handshake.
- Arithmetic:
  - The counter is unsigned nbits wide.
  - Decrement never wraps, because COUNT always exits on the 1->0 step.
  - The maximum load value is 2^nbits-1 (7 for the default).
- X-safety: out is never X after the first reset edge. Inputs are sampled only in the states listed above.

Decomposition:
- Shared package seq_count_pkg holds:
  - a state typedef enum {IDLE, COUNT, DONE} sized 2 bits;
  - constant encodings: IDLE=0, COUNT=1, DONE=2.
- One natural sub-module, seq_count_nb_bin_down_ld: a parameterized register with synchronous active-low reset, a load (ld, ld_val) and a decrement enable (dec), where ld has priority over dec.
- The top level holds the FSM, the handshake logic and the sub-module instance.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random inputs, then release -> out=0, req_rdy=1, done_val=0.
- Basic count: load 5 with en=1 continuously and done_rdy=1 -> out sequence 5,4,3,2,1,0. done_val is high exactly in the cycle where out first reads 0, and req_rdy returns to 1 on the next cycle.
- Enable gaps: load 3, then en pattern 1,0,0,1,0,1 -> out 3,2,2,2,1,1,0, then DONE.
- Zero and max load:
  - Load 0 -> done_val=1 the next cycle, with out=0.
  - Load 7 with en=1 -> done_val after 7 cycles.
- Backpressure and ignored inputs:
  - Load 2 and reach DONE with done_rdy=0 for 4 cycles while req_val=1 and en=1 -> done_val stays 1, out stays 0, req_rdy stays 0.
  - Then done_rdy=1 -> IDLE, and the pending req_val is accepted the following cycle.
- Reset mid-operation: load 6, count to 4, then apply reset=0 for one cycle -> out=0 and IDLE, with done_val never asserted.
